line_clear_engine: RTL and testbench
====================================

Name: line_clear_engine

Overview:
- Consumes the flat playfield bit-vector that the game controller writes, and produces the compacted board after full rows are removed.
- Scans rows bottom-to-top, one row per clock, and drops every non-full row down over the cleared ones.
- Reports the number of lines cleared and a per-row full mask for scoring and display flash.
- Sits between the game FSM (which writes the board) and the board register feeding display.

Parameters:
- WIDTH, 10, cells per row.
- HEIGHT, 20, rows; WIDTH*HEIGHT equals `BOARD_SIZE.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-low (asserted when 0, sampled on posedge clk).
- start  input  1  one-cycle request; accepted only when busy=0.
- board_in  input  WIDTH*HEIGHT  playfield; cell (row r, col c) at bit r*WIDTH+c; row 0 top, row HEIGHT-1 bottom; 1 = filled.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse; board_out, lines and full_mask valid from this cycle.
- board_out  output  WIDTH*HEIGHT  compacted board, same bit mapping.
- lines  output  clog2(HEIGHT+1) (5 at default)  count of full rows removed.
- full_mask  output  HEIGHT  bit r = 1 iff row r of the captured board was full.

Behaviour:
- Reset (rst=0 at posedge): state IDLE; busy=0, done=0, board_out=0, lines=0, full_mask=0; internal buffers cleared. Reset wins over start and aborts any scan in progress; no done pulse is issued for an aborted scan.
- States are IDLE, SCAN and DONE.
- IDLE:
  - On start=1 at posedge T: capture board_in into src buffer.
  - Clear dst buffer to all zeros, set rd=HEIGHT-1, wr=HEIGHT-1, cnt=0, mask=0.
  - Go to SCAN; busy=1 from T+1.
- SCAN: one row per cycle, processing row rd of src.
  - If all WIDTH bits of the row are 1: cnt+=1, mask[rd]=1, wr unchanged.
  - Otherwise: dst row wr = src row rd, then wr-=1.
  - Then rd-=1.
  - After row 0 is processed (HEIGHT cycles, T+1..T+HEIGHT), go to DONE.
- DONE (cycle T+HEIGHT+1):
  - board_out=dst, lines=cnt, full_mask=mask; done=1 for exactly this cycle; busy=0.
  - Return to IDLE.
- Total latency: done asserts HEIGHT+1 cycles after the start edge (21 at default).
- board_out, lines and full_mask hold their values until the next done or reset.
- Rows above the final wr remain 0 because dst was pre-cleared; no separate fill phase is needed.
- Empty rows are copied like any non-full row. Row order is preserved; rows only move downward.
- start while busy=1 or in DONE is ignored, not queued.
- board_in changes during SCAN have no effect, because only the captured src is used.
- start asserted in the same cycle done pulses is ignored; start is accepted on the following IDLE cycle.
- Index counters rd and wr are clog2(HEIGHT) bits. wr never underflows, because at most HEIGHT non-full rows are written. lines saturates naturally at HEIGHT.

Test Plan:
- Empty board, start at cycle 0 -> done at cycle 21; board_out=0, lines=0, full_mask=0; busy high cycles 1-20.
- Row 19 full; row 18 cols 1-7 filled -> board_out has cols 1-7 of row 19 set, row 18 empty; lines=1; full_mask=20'h80000.
- Rows 17 and 19 full; row 18 col 0 set; row 16 col 9 set -> row 19 col 0, row 18 col 9, all other rows 0; lines=2; full_mask bits 17 and 19 set.
- All 200 cells set -> board_out=0, lines=20, full_mask=all ones.
- Second start at cycle 5 and board_in changed mid-scan -> ignored; single done at cycle 21 reflecting the board captured at cycle 0; no second done.
- rst=0 at cycle 10 of a scan -> next cycle busy=0, outputs 0, no done. New start after release completes normally in 21 cycles.

Source files
------------

// File: rtl/line_clear_engine.sv
// rtl/line_clear_engine.sv - removes full rows from a playfield, one row per clock, bottom to top
module line_clear_engine #(
  parameter int WIDTH  = 10,
  parameter int HEIGHT = 20
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [WIDTH*HEIGHT-1:0]         board_in,
  output logic                            busy,
  output logic                            done,
  output logic [WIDTH*HEIGHT-1:0]         board_out,
  output logic [$clog2(HEIGHT+1)-1:0]     lines,
  output logic [HEIGHT-1:0]               full_mask
);

  localparam int N  = WIDTH * HEIGHT;
  localparam int CW = $clog2(HEIGHT + 1);
  localparam int IW = $clog2(HEIGHT);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t          state_q;
  logic [N-1:0]    src_q, dst_q, board_q;
  logic [IW-1:0]   rd_q, wr_q;
  logic [CW-1:0]   cnt_q, lines_q;
  logic [HEIGHT-1:0] mask_q, fmask_q;
  logic            busy_q, done_q;

  logic [WIDTH-1:0]  src_row;
  logic              row_full;
  logic [N-1:0]      dst_d;
  logic [CW-1:0]     cnt_d;
  logic [HEIGHT-1:0] mask_d;

  // Per-row datapath: either drop the full row or copy it down to the write pointer.
  always_comb begin
    src_row  = src_q[rd_q*WIDTH +: WIDTH];
    row_full = &src_row;
    dst_d    = dst_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    if (row_full) begin
      cnt_d        = cnt_q + 1'b1;
      mask_d[rd_q] = 1'b1;
    end else begin
      dst_d[wr_q*WIDTH +: WIDTH] = src_row;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      board_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      lines_q <= '0;
      mask_q  <= '0;
      fmask_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            src_q   <= board_in;
            dst_q   <= '0;
            rd_q    <= IW'(HEIGHT - 1);
            wr_q    <= IW'(HEIGHT - 1);
            cnt_q   <= '0;
            mask_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          dst_q  <= dst_d;
          cnt_q  <= cnt_d;
          mask_q <= mask_d;
          if (!row_full && wr_q != '0) wr_q <= wr_q - 1'b1;
          // Row 0 is the last one; publish the results on the same edge.
          if (rd_q == '0) begin
            board_q <= dst_d;
            lines_q <= cnt_d;
            fmask_q <= mask_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            rd_q <= rd_q - 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign board_out = board_q;
  assign lines     = lines_q;
  assign full_mask = fmask_q;

endmodule

// File: tb/tb_line_clear_engine.sv
// tb/tb_line_clear_engine.sv - self-checking bench for line_clear_engine
module tb_line_clear_engine;

  localparam int W = 10;
  localparam int H = 20;
  localparam int N = W * H;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [N-1:0]   board_in;
  logic           busy, done;
  logic [N-1:0]   board_out;
  logic [4:0]     lines;
  logic [H-1:0]   full_mask;

  int nvec = 0;
  int nerr = 0;

  line_clear_engine #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .start(start), .board_in(board_in),
    .busy(busy), .done(done), .board_out(board_out),
    .lines(lines), .full_mask(full_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] b;
    logic [N-1:0] exp_b;
    int           exp_l;
    logic [H-1:0] exp_m;
  } vec_t;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: keep non-full rows in bottom-to-top order and stack them from the bottom.
  task automatic model(input logic [N-1:0] b, output logic [N-1:0] ob,
                       output int ln, output logic [H-1:0] m);
    logic [W-1:0] keep[$];
    logic [W-1:0] row;
    ob = '0; ln = 0; m = '0;
    for (int r = H - 1; r >= 0; r--) begin
      row = b[r*W +: W];
      if (row == {W{1'b1}}) begin
        ln++;
        m[r] = 1'b1;
      end else begin
        keep.push_back(row);
      end
    end
    for (int k = 0; k < keep.size(); k++) ob[(H-1-k)*W +: W] = keep[k];
  endtask

  task automatic run_scan(input logic [N-1:0] b, input int extra_at, input logic [N-1:0] alt,
                          output logic [N-1:0] ob, output int ol, output logic [H-1:0] om,
                          output int lat, output int ndone, output int nbusy, output logic hold_ok);
    @(negedge clk);
    board_in = b;
    start = 1'b1;
    lat = 0; ndone = 0; nbusy = 0; hold_ok = 1'b1;
    ob = '0; ol = 0; om = '0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == extra_at) begin
        start = 1'b1;
        board_in = alt;
      end
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (lat == 0) begin
          lat = i;
          ob = board_out;
          ol = int'(lines);
          om = full_mask;
        end
      end
      if (lat != 0 && i > lat && (board_out !== ob || int'(lines) != ol || full_mask !== om))
        hold_ok = 1'b0;
    end
    start = 1'b0;
  endtask

  vec_t         tab[5];
  logic [N-1:0] ob, eb, alt, b;
  logic [H-1:0] om, em;
  int           ol, el, lat, nd, nb;
  logic         hold_ok;

  initial begin
    rst = 1'b0; start = 1'b0; board_in = '0;

    foreach (tab[i]) begin
      tab[i].b = '0; tab[i].exp_b = '0; tab[i].exp_l = 0; tab[i].exp_m = '0;
    end
    for (int c = 0; c < W; c++) tab[1].b[19*W + c] = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tab[1].b[18*W + c] = 1'b1;
      tab[1].exp_b[19*W + c] = 1'b1;
    end
    tab[1].exp_l = 1; tab[1].exp_m = 20'h80000;
    for (int c = 0; c < W; c++) begin
      tab[2].b[19*W + c] = 1'b1;
      tab[2].b[17*W + c] = 1'b1;
    end
    tab[2].b[18*W + 0] = 1'b1;
    tab[2].b[16*W + 9] = 1'b1;
    tab[2].exp_b[19*W + 0] = 1'b1;
    tab[2].exp_b[18*W + 9] = 1'b1;
    tab[2].exp_l = 2; tab[2].exp_m = 20'hA0000;
    tab[3].b = '1; tab[3].exp_l = 20; tab[3].exp_m = 20'hFFFFF;
    for (int c = 0; c < W; c++) tab[4].b[c] = 1'b1;
    tab[4].b[5*W + 3] = 1'b1;
    tab[4].exp_b[5*W + 3] = 1'b1;
    tab[4].exp_l = 1; tab[4].exp_m = 20'h00001;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", N'(busy), '0);
    chk("reset_done", N'(done), '0);
    chk("reset_board", board_out, '0);
    chk("reset_lines", N'(lines), '0);
    chk("reset_mask", N'(full_mask), '0);
    rst = 1'b1;

    foreach (tab[i]) begin
      run_scan(tab[i].b, 0, '0, ob, ol, om, lat, nd, nb, hold_ok);
      chk($sformatf("tab%0d_board", i), ob, tab[i].exp_b);
      chk($sformatf("tab%0d_lines", i), N'(ol), N'(tab[i].exp_l));
      chk($sformatf("tab%0d_mask", i), N'(om), N'(tab[i].exp_m));
      chk($sformatf("tab%0d_latency", i), N'(lat), N'(21));
      chk($sformatf("tab%0d_busy_cycles", i), N'(nb), N'(20));
      chk($sformatf("tab%0d_hold", i), N'(hold_ok), N'(1));
    end

    for (int t = 0; t < 30; t++) begin
      b = '0;
      for (int r = 0; r < H; r++) begin
        case ($urandom_range(0, 3))
          0: b[r*W +: W] = '1;
          1: b[r*W +: W] = '0;
          default: b[r*W +: W] = W'($urandom);
        endcase
      end
      model(b, eb, el, em);
      run_scan(b, 0, '0, ob, ol, om, lat, nd, nb, hold_ok);
      chk($sformatf("rnd%0d_board", t), ob, eb);
      chk($sformatf("rnd%0d_lines", t), N'(ol), N'(el));
      chk($sformatf("rnd%0d_mask", t), N'(om), N'(em));
      chk($sformatf("rnd%0d_latency", t), N'(lat), N'(21));
    end

    // Second start mid-scan with a different board: must be ignored.
    b = tab[2].b;
    alt = '1;
    run_scan(b, 5, alt, ob, ol, om, lat, nd, nb, hold_ok);
    chk("midstart_board", ob, tab[2].exp_b);
    chk("midstart_lines", N'(ol), N'(2));
    chk("midstart_latency", N'(lat), N'(21));
    chk("midstart_ndone", N'(nd), N'(1));
    chk("midstart_busy_cycles", N'(nb), N'(20));

    // Start raised during the done cycle: must be ignored as well.
    run_scan(tab[1].b, 21, tab[3].b, ob, ol, om, lat, nd, nb, hold_ok);
    chk("donestart_board", ob, tab[1].exp_b);
    chk("donestart_ndone", N'(nd), N'(1));
    chk("donestart_busy_cycles", N'(nb), N'(20));

    // Reset in the middle of a scan aborts it without a done pulse.
    @(negedge clk);
    board_in = tab[3].b;
    start = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", N'(busy), '0);
    chk("abort_done", N'(done), '0);
    chk("abort_board", board_out, '0);
    chk("abort_lines", N'(lines), '0);
    chk("abort_mask", N'(full_mask), '0);
    rst = 1'b1;
    nd = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    chk("abort_no_activity", N'(nd), '0);
    run_scan(tab[2].b, 0, '0, ob, ol, om, lat, nd, nb, hold_ok);
    chk("after_abort_board", ob, tab[2].exp_b);
    chk("after_abort_mask", N'(om), N'(tab[2].exp_m));
    chk("after_abort_latency", N'(lat), N'(21));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
